// File: rtl/audio_pkg.sv
// Shared audio-path definitions for the PDM capture and transmit blocks.
//   WORD_LENGTH     : default PCM word width (also PDM bits per word)
//   pcm_word_t      : unsigned offset-binary PCM word
//   pdm_mod_state_t : PDM modulator FSM states
package audio_pkg;

  localparam int unsigned WORD_LENGTH = 16;

  typedef logic [WORD_LENGTH-1:0] pcm_word_t;

  typedef enum logic {
    StIdle,
    StRun
  } pdm_mod_state_t;

endpackage

// File: rtl/pdm_edge_detector.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Produces a one-cycle pulse in the clock_i domain for every rising edge of an
// asynchronous input. Pulse appears 2-3 clock_i cycles after the input edge.
//   clock_i  : system clock
//   reset_i  : asynchronous active-low reset
//   signal_i : asynchronous input
//   rise_o   : one-cycle pulse on a synchronised rising edge
module pdm_edge_detector (
  input  logic clock_i,
  input  logic reset_i,
  input  logic signal_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= signal_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM transmitter.
// Accepts unsigned PCM words over valid/ready into a one-word holding register
// and emits one PDM bit per rising edge of the external pdm_clk_i.
//   clock_i     : system clock
//   reset_i     : asynchronous active-low reset
//   enable_i    : run enable; dropping it aborts the current word immediately
//   pdm_clk_i   : PDM bit clock, asynchronous to clock_i
//   pdm_data_o  : PDM bitstream (registered)
//   data_i      : PCM word, loaded when valid_i && ready_o
//   valid_i     : data_i valid
//   ready_o     : holding register empty
//   done_o      : one-cycle pulse when the last bit of a word is emitted
//   underflow_o : one-cycle pulse at a word boundary with nothing held
//   active_o    : high while running
module pdm_modulator
  import audio_pkg::*;
#(
  parameter int unsigned WORD_LENGTH        = audio_pkg::WORD_LENGTH,
  parameter int unsigned SYSTEM_FREQUENCY   = 100,
  parameter int unsigned SAMPLING_FREQUENCY = 10
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   pdm_clk_i,
  output logic                   pdm_data_o,
  input  logic [WORD_LENGTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   underflow_o,
  output logic                   active_o
);

  localparam int unsigned CntW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_LENGTH - 1);

  // The synchroniser needs at least 4 system cycles per PDM bit.
  if (SYSTEM_FREQUENCY < 4 * SAMPLING_FREQUENCY) begin : g_freq_check
    $error("pdm_clk_i too fast for clock_i");
  end

  pdm_mod_state_t         state_q, state_d;
  logic [WORD_LENGTH-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [WORD_LENGTH-1:0] active_q, active_d;
  logic [WORD_LENGTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   pdm_q, pdm_d;
  logic [WORD_LENGTH:0]   sum;
  logic                   bit_tick, move, accept, done, underflow;

  pdm_edge_detector u_edge (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .signal_i (pdm_clk_i),
    .rise_o   (bit_tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pdm_d       = pdm_q;
    done        = 1'b0;
    underflow   = 1'b0;
    move        = 1'b0;
    accept      = valid_i & ~hold_full_q;
    sum         = {1'b0, acc_q} + {1'b0, active_q};

    case (state_q)
      StIdle: begin
        pdm_d = 1'b0;
        if (enable_i && hold_full_q) begin
          move    = 1'b1;
          state_d = StRun;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (!enable_i) begin
          // Disable wins over a coincident tick; active word is dropped.
          state_d  = StIdle;
          pdm_d    = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          active_d = '0;
        end else if (bit_tick) begin
          acc_d = sum[WORD_LENGTH-1:0];
          pdm_d = sum[WORD_LENGTH];
          if (cnt_q == LastBit) begin
            cnt_d = '0;
            done  = 1'b1;
            // acc is deliberately kept so quantisation error carries over.
            if (hold_full_q) move = 1'b1;
            else             underflow = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (move) begin
      active_d    = hold_q;
      hold_full_d = 1'b0;
    end
    // Accept only when empty, so it never collides with a move of a full register.
    if (accept) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      pdm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pdm_q       <= pdm_d;
    end
  end

  assign pdm_data_o  = pdm_q;
  assign ready_o     = ~hold_full_q;
  assign done_o      = done;
  assign underflow_o = underflow;
  assign active_o    = (state_q == StRun);

  // Ticks closer than 4 cycles mean pdm_clk_i is too fast to synchronise.
  a_tick_spacing: assert property (@(posedge clock_i) disable iff (!reset_i)
    bit_tick |-> !$past(bit_tick, 1) && !$past(bit_tick, 2) && !$past(bit_tick, 3));

endmodule

// File: tb/tb_pdm_modulator.sv
module tb_pdm_modulator;
  import audio_pkg::*;

  localparam int unsigned WL = audio_pkg::WORD_LENGTH;
  localparam int Full = 1 << WL;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          enable_i = 1'b0;
  logic          pdm_clk_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [WL-1:0] data_i = '0;
  logic          pdm_data_o, ready_o, done_o, underflow_o, active_o;

  pdm_modulator #(
    .WORD_LENGTH        (WL),
    .SYSTEM_FREQUENCY   (100),
    .SAMPLING_FREQUENCY (10)
  ) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .pdm_clk_i   (pdm_clk_i),
    .pdm_data_o  (pdm_data_o),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .underflow_o (underflow_o),
    .active_o    (active_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: words still to be offered, words accepted but not yet
  // playing, and the playing word with its running error and bit position.
  int m_feed[$];
  int m_hold[$];
  bit m_run = 1'b0;
  int m_cur = 0;
  int m_acc = 0;
  int m_idx = 0;
  bit m_pdm = 1'b0;
  bit offer_acc = 1'b0;

  task automatic model_stop();
    m_run = 1'b0;
    m_acc = 0;
    m_idx = 0;
    m_pdm = 1'b0;
  endtask

  task automatic model_start();
    if (enable_i && !m_run && m_hold.size() > 0) begin
      m_run = 1'b1;
      m_cur = m_hold.pop_front();
      m_acc = 0;
      m_idx = 0;
    end
  endtask

  // One PDM clock period: 5 cycles high, 5 low. Handshakes and enable changes
  // only happen in the low half, well away from the bit tick.
  task automatic run_period(input bit drop_tick, input int en_low, input string tag);
    int nd = 0;
    int nu = 0;
    int ed = 0;
    int eu = 0;
    int s;
    @(negedge clock_i);
    pdm_clk_i = 1'b1;
    nd += int'(done_o);
    nu += int'(underflow_o);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      // Second negedge after the rise: the tick is live, drop enable on it.
      if (drop_tick && i == 1) enable_i = 1'b0;
      nd += int'(done_o);
      nu += int'(underflow_o);
    end
    if (drop_tick) begin
      model_stop();
    end else if (m_run) begin
      s     = m_acc + m_cur;
      m_pdm = (s >= Full);
      m_acc = s % Full;
      m_idx++;
      if (m_idx == int'(WL)) begin
        m_idx = 0;
        ed    = 1;
        if (m_hold.size() > 0) m_cur = m_hold.pop_front();
        else                   eu = 1;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      if (i == 0) pdm_clk_i = 1'b0;
      nd += int'(done_o);
      nu += int'(underflow_o);
      if (valid_i && offer_acc) m_hold.push_back(m_feed.pop_front());
      valid_i = 1'b0;
      if (i == 0 && en_low >= 0) begin
        enable_i = (en_low != 0);
        if (!enable_i) model_stop();
      end
      if (i <= 2 && m_feed.size() > 0) begin
        data_i  = WL'(m_feed[0]);
        valid_i = 1'b1;
      end
      offer_acc = valid_i && ready_o;
    end
    model_start();
    check_eq({tag, ":pdm"}, int'(pdm_data_o), int'(m_pdm));
    check_eq({tag, ":done"}, nd, ed);
    check_eq({tag, ":underflow"}, nu, eu);
    check_eq({tag, ":ready"}, int'(ready_o), int'(m_hold.size() == 0));
    check_eq({tag, ":active"}, int'(active_o), int'(m_run));
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) run_period(1'b0, -1, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ":rst_pdm"}, int'(pdm_data_o), 0);
    check_eq({tag, ":rst_ready"}, int'(ready_o), 1);
    check_eq({tag, ":rst_done"}, int'(done_o), 0);
    check_eq({tag, ":rst_underflow"}, int'(underflow_o), 0);
    check_eq({tag, ":rst_active"}, int'(active_o), 0);
  endtask

  initial begin
    // Power-on reset
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge clock_i);
    reset_i = 1'b1;

    // Zero word, resupplied each time: constant 0, no underflow
    for (int i = 0; i < 4; i++) m_feed.push_back(0);
    run_period(1'b0, 1, "zero");
    run_n(48, "zero");
    run_period(1'b0, 0, "zero_off");

    // 0x8000: alternating bits; then 0xFFFF: 0 followed by 15 ones
    m_feed.push_back(32'h8000);
    run_period(1'b0, 1, "half");
    run_n(16, "half");
    run_period(1'b0, 0, "half_off");
    m_feed.push_back(32'hFFFF);
    run_period(1'b0, 1, "full");
    run_n(16, "full");
    run_period(1'b0, 0, "full_off");

    // Single 0x4000 then starve: done+underflow together, word repeats
    m_feed.push_back(32'h4000);
    run_period(1'b0, 1, "quarter");
    run_n(32, "quarter");
    run_period(1'b0, 0, "quarter_off");

    // Back-to-back words, third waits for the boundary transfer
    m_feed.push_back(32'h8000);
    m_feed.push_back(32'h4000);
    m_feed.push_back(32'h2000);
    run_period(1'b0, 1, "b2b");
    run_n(48, "b2b");
    run_period(1'b0, 0, "b2b_off");

    // Disable on the bit-7 tick, then restart from the held word
    m_feed.push_back(32'h8000);
    m_feed.push_back(32'h6000);
    run_period(1'b0, 1, "abort");
    run_n(7, "abort");
    run_period(1'b1, -1, "abort_tick");
    run_period(1'b0, 1, "abort_re");
    run_n(17, "abort_re");

    // Reset mid-run
    m_feed.push_back(32'h5555);
    run_n(3, "pre_rst");
    @(negedge clock_i);
    reset_i = 1'b0;
    valid_i = 1'b0;
    #1;
    check_reset_outputs("midrun");
    m_feed.delete();
    m_hold.delete();
    model_stop();
    offer_acc = 1'b0;
    @(negedge clock_i);
    reset_i = 1'b1;
    run_n(3, "post_rst");

    // Randomized traffic
    for (int p = 0; p < 200; p++) begin
      int en = -1;
      bit drop = 1'b0;
      if (m_feed.size() < 2 && $urandom_range(3, 0) != 0) begin
        case ($urandom_range(7, 0))
          0:       m_feed.push_back(0);
          1:       m_feed.push_back(Full - 1);
          default: m_feed.push_back(int'($urandom_range(Full - 1, 0)));
        endcase
      end
      if (enable_i && $urandom_range(29, 0) == 0) en = 0;
      else if (!enable_i && $urandom_range(2, 0) == 0) en = 1;
      if (enable_i && en < 0 && $urandom_range(49, 0) == 0) drop = 1'b1;
      run_period(drop, en, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
